// File: rtl/isw_pkg.sv
// isw_pkg: shared helpers for the n-th order ISW AND gadget (random-word count and pair index mapping).
package isw_pkg;
  localparam int ISW_DEF_WIDTH = 8;
  function automatic int num_rand(input int s);
    return s * (s - 1) / 2;
  endfunction
  function automatic int rand_idx(input int i, input int j, input int s);
    return i * s - i * (i + 1) / 2 + (j - i - 1);
  endfunction
endpackage

// File: rtl/isw_and_norder_pipe_cross.sv
// isw_cross_term: registered cross products for one share pair i<j; ISW_AND_ZERO_IDLE_EN zeroes the registers while idle.
module isw_cross_term
  import isw_pkg::*;
#(
  parameter int WIDTH = ISW_DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] xj,
  input  logic [WIDTH-1:0] yi,
  input  logic [WIDTH-1:0] yj,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] rd_o,
  output logic [WIDTH-1:0] tu_o
);
  logic [WIDTH-1:0] t, u, rd;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t  <= '0;
      u  <= '0;
      rd <= '0;
`ifdef ISW_AND_ZERO_IDLE_EN
    end else begin
      t  <= en_i ? r ^ (xi & yj) : '0;
      u  <= en_i ? xj & yi : '0;
      rd <= en_i ? r : '0;
    end
`else
    end else if (en_i) begin
      t  <= r ^ (xi & yj);
      u  <= xj & yi;
      rd <= r;
    end
`endif
  end
  // t and u are only merged after both are registered
  assign tu_o = t ^ u;
  assign rd_o = rd;
endmodule

// File: rtl/isw_and_norder_pipe.sv
// isw_and_norder_pipe: two-stage d-th order ISW masked AND with valid flag.
// Optional macro ISW_AND_ZERO_IDLE_EN: stage registers load zero instead of holding while idle.
module isw_and_norder_pipe
  import isw_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int WIDTH      = ISW_DEF_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    valid_i,
  input  logic [NUM_SHARES*WIDTH-1:0]             X_i,
  input  logic [NUM_SHARES*WIDTH-1:0]             Y_i,
  input  logic [num_rand(NUM_SHARES)*WIDTH-1:0]   R_i,
  output logic                                    valid_o,
  output logic [NUM_SHARES*WIDTH-1:0]             Q_o
);
  localparam int NUM_RAND = num_rand(NUM_SHARES);
  logic                               v1;
  logic [NUM_SHARES-1:0][WIDTH-1:0]   c, z, q;
  logic [NUM_RAND-1:0][WIDTH-1:0]     rd, tu;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c  <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= valid_i;
`ifdef ISW_AND_ZERO_IDLE_EN
      c  <= valid_i ? X_i & Y_i : '0;
`else
      if (valid_i) c <= X_i & Y_i;
`endif
    end
  end
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_SHARES; j++) begin : g_j
      localparam int K = rand_idx(i, j, NUM_SHARES);
      isw_cross_term #(.WIDTH(WIDTH)) u_ct (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (valid_i),
        .xi    (X_i[i*WIDTH +: WIDTH]),
        .xj    (X_i[j*WIDTH +: WIDTH]),
        .yi    (Y_i[i*WIDTH +: WIDTH]),
        .yj    (Y_i[j*WIDTH +: WIDTH]),
        .r     (R_i[K*WIDTH +: WIDTH]),
        .rd_o  (rd[K]),
        .tu_o  (tu[K])
      );
    end
  end
  always_comb begin
    z = c;
    for (int a = 0; a < NUM_SHARES; a++)
      for (int b = 0; b < NUM_SHARES; b++)
        if (a < b) z[a] ^= rd[rand_idx(a, b, NUM_SHARES)];
        else if (a > b) z[a] ^= tu[rand_idx(b, a, NUM_SHARES)];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q       <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= v1;
`ifdef ISW_AND_ZERO_IDLE_EN
      q       <= v1 ? z : '0;
`else
      if (v1) q <= z;
`endif
    end
  end
  assign Q_o = q;
endmodule
